tt_um_fsm_haz: RTL and testbench

- Pipeline hazard-resolution controller packaged as a TinyTapeout user tile.
- Each cycle it samples hazard flags for data, structural and control hazards, plus branch-resolution flags, from `ui_in`.
- A prioritised Moore FSM turns these into pipeline control outputs: stall, flush, forward-enable, PC write-enable and redirect.
- It also drives a consecutive-stall counter on `uio_out`.

---
 rtl/tt_um_fsm_haz.sv | 113 +++++++++++
 tb/tb_tt_um_fsm_haz.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_fsm_haz.sv
// Pipeline hazard-resolution controller (TinyTapeout tile).
// A prioritised Moore FSM drives stall/flush/forward/PC control and a consecutive-stall counter.
//
// state   | meaning
// IDLE    | no hazard, pipeline advancing
// FWD     | data hazard satisfied by forwarding
// STALL_D | data hazard, forwarding unavailable
// STALL_S | structural hazard
// BR_WAIT | branch in flight, outcome unresolved
// BR_OK   | branch resolved, prediction correct
// FLUSH1  | mispredict, first flush cycle, PC redirected
// FLUSH2  | mispredict, second flush cycle
module tt_um_fsm_haz (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FWD     = 3'd1,
    STALL_D = 3'd2,
    STALL_S = 3'd3,
    BR_WAIT = 3'd4,
    BR_OK   = 3'd5,
    FLUSH1  = 3'd6,
    FLUSH2  = 3'd7
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] stall_cnt_q, stall_cnt_d;

  logic data_hz, str_hz, ctrl_hz, branch_res, fwrd_ok, crct_pred;
  logic cur_stall, nxt_stall;
  logic stall, flush, fwd_en, pc_we, redirect;

  assign data_hz    = ui_in[7];
  assign str_hz     = ui_in[6];
  assign ctrl_hz    = ui_in[5];
  assign branch_res = ui_in[4];
  assign fwrd_ok    = ui_in[3];
  assign crct_pred  = ui_in[2];

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in, ui_in[1:0]};

  function automatic logic is_stall(input state_e s);
    return (s == STALL_D) || (s == STALL_S) || (s == BR_WAIT);
  endfunction

  always_comb begin
    state_d = IDLE;
    if (state_q == FLUSH1) begin
      state_d = FLUSH2;
    end else if (ctrl_hz && branch_res && !crct_pred) begin
      state_d = FLUSH1;
    end else if (ctrl_hz && branch_res) begin
      state_d = BR_OK;
    end else if (ctrl_hz) begin
      state_d = BR_WAIT;
    end else if (data_hz && fwrd_ok) begin
      state_d = FWD;
    end else if (data_hz) begin
      state_d = STALL_D;
    end else if (str_hz) begin
      state_d = STALL_S;
    end
  end

  // Counting carries across stall kinds; any non-stall state clears it.
  always_comb begin
    cur_stall   = is_stall(state_q);
    nxt_stall   = is_stall(state_d);
    stall_cnt_d = 4'd0;
    if (nxt_stall) begin
      if (!cur_stall) begin
        stall_cnt_d = 4'd1;
      end else if (stall_cnt_q == 4'hF) begin
        stall_cnt_d = 4'hF;
      end else begin
        stall_cnt_d = stall_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stall_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    stall    = is_stall(state_q);
    flush    = (state_q == FLUSH1) || (state_q == FLUSH2);
    fwd_en   = (state_q == FWD);
    redirect = (state_q == FLUSH1);
    pc_we    = !stall;
  end

  assign uo_out  = {state_q, redirect, pc_we, fwd_en, flush, stall};
  assign uio_out = {4'b0000, stall_cnt_q};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_tt_um_fsm_haz.sv
// Directed self-checking bench for tt_um_fsm_haz.
// Inputs change #1 after a rising edge; outputs are checked at that same point.
module tb_tt_um_fsm_haz;

  localparam logic [7:0] F_DATA = 8'h80;
  localparam logic [7:0] F_STR  = 8'h40;
  localparam logic [7:0] F_CTRL = 8'h20;
  localparam logic [7:0] F_BR   = 8'h10;
  localparam logic [7:0] F_FWRD = 8'h08;
  localparam logic [7:0] F_CRCT = 8'h04;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int errors = 0;
  int checks = 0;

  tt_um_fsm_haz dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ui_in = 8'h00;
    #3;
    checks++;
    if (uo_out !== 8'h08) begin
      errors++;
      $display("FAIL reset_uo: got %h want 08", uo_out);
    end
    checks++;
    if (uio_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_uio: got %h want 00", uio_out);
    end
    checks++;
    if (uio_oe !== 8'h0F) begin
      errors++;
      $display("FAIL reset_oe: got %h want 0F", uio_oe);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (uo_out !== 8'h08) begin
      errors++;
      $display("FAIL reset_release: got %h want 08", uo_out);
    end
  endtask

  task automatic test_correct_pred();
    ui_in = F_CTRL | F_BR | F_CRCT;
    tick();
    checks++;
    if (uo_out !== 8'hA8 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL br_ok: got uo=%h uio=%h want uo=A8 uio=00", uo_out, uio_out);
    end
    ui_in = 8'h00;
    tick();
    checks++;
    if (uo_out !== 8'h08) begin
      errors++;
      $display("FAIL br_ok_idle: got %h want 08", uo_out);
    end
  endtask

  task automatic test_mispredict();
    ui_in = F_DATA;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (uo_out !== 8'h41 || uio_out !== 8'(i)) begin
        errors++;
        $display("FAIL mp_stall_d[%0d]: got uo=%h uio=%h want uo=41 uio=%h", i, uo_out, uio_out, 8'(i));
      end
    end
    ui_in = F_CTRL | F_BR | F_DATA;
    tick();
    checks++;
    if (uo_out !== 8'hDA || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL mp_flush1: got uo=%h uio=%h want uo=DA uio=00", uo_out, uio_out);
    end
    ui_in = F_DATA;
    tick();
    checks++;
    if (uo_out !== 8'hEA || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL mp_flush2: got uo=%h uio=%h want uo=EA uio=00", uo_out, uio_out);
    end
    tick();
    checks++;
    if (uo_out !== 8'h41 || uio_out !== 8'h01) begin
      errors++;
      $display("FAIL mp_after_flush: got uo=%h uio=%h want uo=41 uio=01", uo_out, uio_out);
    end
    ui_in = 8'h00;
    tick();
    checks++;
    if (uo_out !== 8'h08 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL mp_idle: got uo=%h uio=%h want uo=08 uio=00", uo_out, uio_out);
    end
  endtask

  task automatic test_delayed_branch();
    ui_in = F_CTRL;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++;
      if (uo_out !== 8'h81 || uio_out !== 8'(i)) begin
        errors++;
        $display("FAIL db_wait[%0d]: got uo=%h uio=%h want uo=81 uio=%h", i, uo_out, uio_out, 8'(i));
      end
    end
    ui_in = F_CTRL | F_BR;
    tick();
    checks++;
    if (uo_out !== 8'hDA || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL db_flush1: got uo=%h uio=%h want uo=DA uio=00", uo_out, uio_out);
    end
    ui_in = 8'h00;
    tick();
    checks++;
    if (uo_out !== 8'hEA) begin
      errors++;
      $display("FAIL db_flush2: got %h want EA", uo_out);
    end
    tick();
    checks++;
    if (uo_out !== 8'h08) begin
      errors++;
      $display("FAIL db_idle: got %h want 08", uo_out);
    end
    ui_in = F_CTRL;
    tick();
    checks++;
    if (uo_out !== 8'h81 || uio_out !== 8'h01) begin
      errors++;
      $display("FAIL db_wait2: got uo=%h uio=%h want uo=81 uio=01", uo_out, uio_out);
    end
    ui_in = F_CTRL | F_BR | F_CRCT;
    tick();
    checks++;
    if (uo_out !== 8'hA8 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL db_br_ok: got uo=%h uio=%h want uo=A8 uio=00", uo_out, uio_out);
    end
    ui_in = 8'h00;
    tick();
  endtask

  task automatic test_forwarding();
    ui_in = F_DATA | F_FWRD;
    tick();
    checks++;
    if (uo_out !== 8'h2C || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL fwd: got uo=%h uio=%h want uo=2C uio=00", uo_out, uio_out);
    end
    ui_in = F_DATA;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (uo_out !== 8'h41 || uio_out !== 8'(i)) begin
        errors++;
        $display("FAIL fwd_stall[%0d]: got uo=%h uio=%h want uo=41 uio=%h", i, uo_out, uio_out, 8'(i));
      end
    end
    ui_in = 8'h00;
    tick();
    checks++;
    if (uo_out !== 8'h08 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL fwd_clear: got uo=%h uio=%h want uo=08 uio=00", uo_out, uio_out);
    end
  endtask

  task automatic test_priority();
    int exp_cnt;
    ui_in = F_DATA | F_STR;
    tick();
    checks++;
    if (uo_out !== 8'h41) begin
      errors++;
      $display("FAIL prio_data_str: got %h want 41", uo_out);
    end
    ui_in = F_CTRL | F_STR;
    tick();
    checks++;
    if (uo_out !== 8'h81 || uio_out !== 8'h02) begin
      errors++;
      $display("FAIL prio_ctrl_str: got uo=%h uio=%h want uo=81 uio=02", uo_out, uio_out);
    end
    ui_in = F_STR;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp_cnt = (i + 2 > 15) ? 15 : i + 2;
      checks++;
      if (uo_out !== 8'h61 || uio_out !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_str[%0d]: got uo=%h uio=%h want uo=61 uio=%h", i, uo_out, uio_out, 8'(exp_cnt));
      end
    end
    ui_in = 8'h00;
    tick();
    checks++;
    if (uo_out !== 8'h08 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL sat_clear: got uo=%h uio=%h want uo=08 uio=00", uo_out, uio_out);
    end
  endtask

  task automatic test_back_to_back();
    ui_in = F_CTRL | F_BR;
    tick();
    checks++;
    if (uo_out !== 8'hDA) begin
      errors++;
      $display("FAIL b2b_flush1a: got %h want DA", uo_out);
    end
    tick();
    checks++;
    if (uo_out !== 8'hEA) begin
      errors++;
      $display("FAIL b2b_flush2: got %h want EA", uo_out);
    end
    tick();
    checks++;
    if (uo_out !== 8'hDA) begin
      errors++;
      $display("FAIL b2b_flush1b: got %h want DA", uo_out);
    end
    ui_in = 8'h00;
    tick();
    tick();
    checks++;
    if (uo_out !== 8'h08) begin
      errors++;
      $display("FAIL b2b_idle: got %h want 08", uo_out);
    end
  endtask

  task automatic test_reset_mid();
    ui_in = F_STR;
    tick();
    tick();
    ui_in = F_CTRL | F_BR;
    tick();
    checks++;
    if (uo_out !== 8'hDA) begin
      errors++;
      $display("FAIL rmid_flush: got %h want DA", uo_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out !== 8'h08 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL rmid_flush_reset: got uo=%h uio=%h want uo=08 uio=00", uo_out, uio_out);
    end
    ui_in = F_STR;
    tick();
    checks++;
    if (uo_out !== 8'h08) begin
      errors++;
      $display("FAIL rmid_hold: got %h want 08", uo_out);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (uo_out !== 8'h61 || uio_out !== 8'h02) begin
      errors++;
      $display("FAIL rmid_stall: got uo=%h uio=%h want uo=61 uio=02", uo_out, uio_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (uo_out !== 8'h08 || uio_out !== 8'h00) begin
      errors++;
      $display("FAIL rmid_stall_reset: got uo=%h uio=%h want uo=08 uio=00", uo_out, uio_out);
    end
    ui_in = 8'h00;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    test_reset();
    test_correct_pred();
    test_mispredict();
    test_delayed_branch();
    test_forwarding();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
